bellek_yanitlayici: RTL



---
 rtl/bellek_paket.sv | 15 +
 rtl/bellek_dizisi.sv | 47 ++++
 rtl/bellek_yanitlayici.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bellek_paket.sv
// Shared constants and state encoding for the memory-side bus responder.
package bellek_paket;

   localparam logic [31:0] BELLEK_ADRES = 32'h8000_0000;
   localparam int unsigned VERI_BIT     = 32;
   localparam int unsigned ADRES_BIT    = 32;
   localparam int unsigned MASKE_BIT    = 4;

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      BEKLE = 2'd1,
      YANIT = 2'd2
   } durum_t;

endpackage

// File: rtl/bellek_dizisi.sv
// Single-port synchronous word RAM with byte-enable write and registered read.
module bellek_dizisi
   import bellek_paket::*;
#(
   parameter int unsigned KELIME_SAYISI = 1024,
   parameter int unsigned GENISLIK      = 32,
   parameter int unsigned IW            = $clog2(KELIME_SAYISI)
) (
   input  logic                 clk,
   input  logic                 yaz_en_i,
   input  logic                 oku_en_i,
   input  logic [IW-1:0]        indeks_i,
   input  logic [GENISLIK-1:0]  yaz_veri_i,
   input  logic [MASKE_BIT-1:0] maske_i,
   output logic [GENISLIK-1:0]  oku_veri_o
);

   logic [GENISLIK-1:0] mem_q [KELIME_SAYISI];
   logic [GENISLIK-1:0] oku_veri_q, oku_veri_d;

   // Storage array: only the enabled byte lanes are overwritten.
   always_ff @(posedge clk) begin
      if (yaz_en_i) begin
         for (int b = 0; b < MASKE_BIT; b++) begin
            if (maske_i[b]) begin
               mem_q[indeks_i][8*b +: 8] <= yaz_veri_i[8*b +: 8];
            end
         end
      end
   end

   // Read port holds its last captured word until the next read.
   always_comb begin
      oku_veri_d = oku_veri_q;
      if (oku_en_i) begin
         oku_veri_d = mem_q[indeks_i];
      end
   end

   // Read data register.
   always_ff @(posedge clk) begin
      oku_veri_q <= oku_veri_d;
   end

   assign oku_veri_o = oku_veri_q;

endmodule

// File: rtl/bellek_yanitlayici.sv
// Memory-side bus responder: valid/busy request handshake, fixed response latency,
// byte-masked writes and address-range/alignment error reporting.
module bellek_yanitlayici
   import bellek_paket::*;
#(
   parameter int unsigned          VERI_BIT        = bellek_paket::VERI_BIT,
   parameter int unsigned          ADRES_BIT       = bellek_paket::ADRES_BIT,
   parameter logic [ADRES_BIT-1:0] BASLANGIC_ADRES = BELLEK_ADRES,
   parameter int unsigned          KELIME_SAYISI   = 1024,
   parameter int unsigned          GECIKME         = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bellek_istek,
   input  logic [ADRES_BIT-1:0] bellek_adres,
   input  logic                 bellek_yaz,
   input  logic [VERI_BIT-1:0]  bellek_yaz_veri,
   input  logic [MASKE_BIT-1:0] bellek_yaz_maske,
   output logic                 bellek_mesgul,
   output logic                 bellek_gecerli,
   output logic [VERI_BIT-1:0]  bellek_oku_veri,
   output logic                 bellek_hata
);

   localparam int unsigned IW = $clog2(KELIME_SAYISI);
   localparam int unsigned SW = (GECIKME > 2) ? $clog2(GECIKME - 1) : 1;
   localparam logic [SW-1:0] SAYAC_YUK = SW'((GECIKME >= 2) ? GECIKME - 2 : 0);

   durum_t               durum_q, durum_d;
   logic [SW-1:0]        sayac_q, sayac_d;
   logic [ADRES_BIT-1:0] adres_q, adres_d;
   logic                 yaz_q, yaz_d;
   logic [VERI_BIT-1:0]  veri_q, veri_d;
   logic [MASKE_BIT-1:0] maske_q, maske_d;
   logic                 yanit_yaz_q, yanit_yaz_d;
   logic                 yanit_hata_q, yanit_hata_d;

   logic                 kabul, isle;
   logic [ADRES_BIT-1:0] is_adres, ofs, kelime_no;
   logic                 is_yaz, erisim_hata;
   logic [VERI_BIT-1:0]  is_veri, ram_oku;
   logic [MASKE_BIT-1:0] is_maske;

   assign bellek_mesgul = (durum_q == BEKLE);
   assign kabul         = bellek_istek & ~bellek_mesgul;

   // With single-cycle latency the commit edge is the acceptance edge, so the live bus
   // fields are used; otherwise the request latched at acceptance is used.
   always_comb begin
      is_adres = adres_q;
      is_yaz   = yaz_q;
      is_veri  = veri_q;
      is_maske = maske_q;
      if (GECIKME == 1) begin
         is_adres = bellek_adres;
         is_yaz   = bellek_yaz;
         is_veri  = bellek_yaz_veri;
         is_maske = bellek_yaz_maske;
      end
   end

   // Address decode: below base, past the last word, or not word aligned.
   always_comb begin
      ofs         = is_adres - BASLANGIC_ADRES;
      kelime_no   = ofs >> 2;
      erisim_hata = (is_adres < BASLANGIC_ADRES) ||
                    (kelime_no >= ADRES_BIT'(KELIME_SAYISI)) ||
                    (is_adres[1:0] != 2'b00);
   end

   // Next-state: handshake, latency countdown and request latching.
   always_comb begin
      durum_d = durum_q;
      sayac_d = sayac_q;
      adres_d = adres_q;
      yaz_d   = yaz_q;
      veri_d  = veri_q;
      maske_d = maske_q;
      case (durum_q)
         BOSTA, YANIT: begin
            durum_d = BOSTA;
            if (kabul) begin
               adres_d = bellek_adres;
               yaz_d   = bellek_yaz;
               veri_d  = bellek_yaz_veri;
               maske_d = bellek_yaz_maske;
               if (GECIKME == 1) begin
                  durum_d = YANIT;
               end else begin
                  durum_d = BEKLE;
                  sayac_d = SAYAC_YUK;
               end
            end
         end
         BEKLE: begin
            if (sayac_q == '0) begin
               durum_d = YANIT;
            end else begin
               sayac_d = sayac_q - SW'(1);
            end
         end
         default: durum_d = BOSTA;
      endcase
   end

   // Commit happens on the edge entering YANIT; remember the response type for muxing.
   always_comb begin
      isle         = (durum_d == YANIT) && !rst;
      yanit_yaz_d  = yanit_yaz_q;
      yanit_hata_d = yanit_hata_q;
      if (isle) begin
         yanit_yaz_d  = is_yaz;
         yanit_hata_d = erisim_hata;
      end
   end

   // State and request registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         durum_q      <= BOSTA;
         sayac_q      <= '0;
         adres_q      <= '0;
         yaz_q        <= 1'b0;
         veri_q       <= '0;
         maske_q      <= '0;
         yanit_yaz_q  <= 1'b0;
         yanit_hata_q <= 1'b0;
      end else begin
         durum_q      <= durum_d;
         sayac_q      <= sayac_d;
         adres_q      <= adres_d;
         yaz_q        <= yaz_d;
         veri_q       <= veri_d;
         maske_q      <= maske_d;
         yanit_yaz_q  <= yanit_yaz_d;
         yanit_hata_q <= yanit_hata_d;
      end
   end

   bellek_dizisi #(
      .KELIME_SAYISI (KELIME_SAYISI),
      .GENISLIK      (VERI_BIT)
   ) u_dizi (
      .clk        (clk),
      .yaz_en_i   (isle & is_yaz & ~erisim_hata),
      .oku_en_i   (isle & ~is_yaz & ~erisim_hata),
      .indeks_i   (kelime_no[IW-1:0]),
      .yaz_veri_i (is_veri),
      .maske_i    (is_maske),
      .oku_veri_o (ram_oku)
   );

   // Response outputs are forced to zero outside the response cycle.
   always_comb begin
      bellek_gecerli  = (durum_q == YANIT);
      bellek_hata     = bellek_gecerli & yanit_hata_q;
      bellek_oku_veri = '0;
      if (bellek_gecerli && !yanit_yaz_q && !yanit_hata_q) begin
         bellek_oku_veri = ram_oku;
      end
   end

endmodule
